// File: rtl/regfile_writeback_arbiter.sv
// rtl/regfile_writeback_arbiter.sv - two-source writeback merge (ALU/LSU) into one register_bank write port
//
// Purpose: buffers ALU and LSU writeback requests in 2-entry FIFOs, picks one head per
// cycle round-robin, and registers the winner onto the register_bank write port. Also
// exports pending_mask, a per-register "write still in flight" bitmask for RAW checks.
//
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_mask/alu_waddr/alu_wdata   ALU request channel
//   lsu_valid/lsu_ready/lsu_mask/lsu_waddr/lsu_wdata   LSU request channel
//   write_en, waddr, wdata_0..wdata_15                  registered bank write port
//   pending_mask                                        bit r set while a write to r is queued or staged
//
// Optional feature: define REGFILE_WB_R0_GUARD_EN to suppress writes to register 0.

module regfile_writeback_arbiter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         alu_valid,
    output logic         alu_ready,
    input  logic [15:0]  alu_mask,
    input  logic [4:0]   alu_waddr,
    input  logic [511:0] alu_wdata,
    input  logic         lsu_valid,
    output logic         lsu_ready,
    input  logic [15:0]  lsu_mask,
    input  logic [4:0]   lsu_waddr,
    input  logic [511:0] lsu_wdata,
    output logic [15:0]  write_en,
    output logic [4:0]   waddr,
    output logic [31:0]  wdata_0,  wdata_1,  wdata_2,  wdata_3,
    output logic [31:0]  wdata_4,  wdata_5,  wdata_6,  wdata_7,
    output logic [31:0]  wdata_8,  wdata_9,  wdata_10, wdata_11,
    output logic [31:0]  wdata_12, wdata_13, wdata_14, wdata_15,
    output logic [31:0]  pending_mask
);
    localparam int LANES      = 16;
    localparam int REGS       = 32;
    localparam int DW         = 32;
    localparam int AW         = 5;
    localparam int FIFO_DEPTH = 2;

    // Source index 0 = ALU, 1 = LSU.
    logic [LANES-1:0]    f_mask_q [2][FIFO_DEPTH];
    logic [AW-1:0]       f_addr_q [2][FIFO_DEPTH];
    logic [LANES*DW-1:0] f_data_q [2][FIFO_DEPTH];
    logic                f_wr_q [2], f_wr_d [2];
    logic                f_rd_q [2], f_rd_d [2];
    logic [1:0]          f_cnt_q [2], f_cnt_d [2];

    logic                last_q, last_d;
    logic [LANES-1:0]    we_q, we_d;
    logic [AW-1:0]       waddr_q, waddr_d;
    logic [LANES*DW-1:0] wdata_q, wdata_d;

    logic                in_valid [2];
    logic [LANES-1:0]    in_mask [2];
    logic [AW-1:0]       in_addr [2];
    logic [LANES*DW-1:0] in_data [2];
    logic                rdy [2], push [2], pop [2], nonempty [2];
    logic                gnt_valid, gnt_src, r0_block;
    logic [LANES-1:0]    h_mask;
    logic [AW-1:0]       h_addr;
    logic [LANES*DW-1:0] h_data;
    logic [REGS-1:0]     pend;

    // A queued entry marks its register pending only if it will actually write something.
    function automatic logic contributes(input logic [LANES-1:0] m, input logic [AW-1:0] a);
`ifdef REGFILE_WB_R0_GUARD_EN
        contributes = (m != '0) && (a != '0);
`else
        contributes = (m != '0) && (a == a);
`endif
    endfunction

    always_comb begin
        in_valid[0] = alu_valid;  in_valid[1] = lsu_valid;
        in_mask[0]  = alu_mask;   in_mask[1]  = lsu_mask;
        in_addr[0]  = alu_waddr;  in_addr[1]  = lsu_waddr;
        in_data[0]  = alu_wdata;  in_data[1]  = lsu_wdata;

        for (int s = 0; s < 2; s++) begin
            // Ready ignores this cycle's pop: a full FIFO never accepts push-through.
            rdy[s]      = (f_cnt_q[s] != 2'(FIFO_DEPTH));
            push[s]     = in_valid[s] && rdy[s];
            nonempty[s] = (f_cnt_q[s] != 2'd0);
        end

        // On a tie grant the source that did not win last time; otherwise the only non-empty one.
        gnt_valid = nonempty[0] || nonempty[1];
        gnt_src   = (nonempty[0] && nonempty[1]) ? ~last_q : nonempty[1];

        for (int s = 0; s < 2; s++) begin
            pop[s]     = gnt_valid && (gnt_src == 1'(s));
            f_wr_d[s]  = f_wr_q[s] ^ push[s];
            f_rd_d[s]  = f_rd_q[s] ^ pop[s];
            f_cnt_d[s] = f_cnt_q[s] + {1'b0, push[s]} - {1'b0, pop[s]};
        end

        h_mask = f_mask_q[gnt_src][f_rd_q[gnt_src]];
        h_addr = f_addr_q[gnt_src][f_rd_q[gnt_src]];
        h_data = f_data_q[gnt_src][f_rd_q[gnt_src]];

`ifdef REGFILE_WB_R0_GUARD_EN
        r0_block = (h_addr == '0);
`else
        r0_block = 1'b0;
`endif

        last_d  = gnt_valid ? gnt_src : last_q;
        we_d    = (gnt_valid && !r0_block) ? h_mask : '0;
        waddr_d = gnt_valid ? h_addr : waddr_q;
        wdata_d = gnt_valid ? h_data : wdata_q;

        pend = '0;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (((f_cnt_q[s] == 2'd2) || ((f_cnt_q[s] == 2'd1) && (f_rd_q[s] == 1'(i)))) &&
                    contributes(f_mask_q[s][i], f_addr_q[s][i]))
                    pend = pend | (REGS'(1) << f_addr_q[s][i]);
            end
        end
        if (we_q != '0)
            pend = pend | (REGS'(1) << waddr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < 2; s++) begin
                for (int i = 0; i < FIFO_DEPTH; i++) begin
                    f_mask_q[s][i] <= '0;
                    f_addr_q[s][i] <= '0;
                    f_data_q[s][i] <= '0;
                end
                f_wr_q[s]  <= 1'b0;
                f_rd_q[s]  <= 1'b0;
                f_cnt_q[s] <= 2'd0;
            end
            last_q  <= 1'b1;
            we_q    <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (push[s]) begin
                    f_mask_q[s][f_wr_q[s]] <= in_mask[s];
                    f_addr_q[s][f_wr_q[s]] <= in_addr[s];
                    f_data_q[s][f_wr_q[s]] <= in_data[s];
                end
                f_wr_q[s]  <= f_wr_d[s];
                f_rd_q[s]  <= f_rd_d[s];
                f_cnt_q[s] <= f_cnt_d[s];
            end
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign alu_ready    = rdy[0];
    assign lsu_ready    = rdy[1];
    assign write_en     = we_q;
    assign waddr        = waddr_q;
    assign pending_mask = pend;
    assign wdata_0  = wdata_q[0*DW  +: DW];
    assign wdata_1  = wdata_q[1*DW  +: DW];
    assign wdata_2  = wdata_q[2*DW  +: DW];
    assign wdata_3  = wdata_q[3*DW  +: DW];
    assign wdata_4  = wdata_q[4*DW  +: DW];
    assign wdata_5  = wdata_q[5*DW  +: DW];
    assign wdata_6  = wdata_q[6*DW  +: DW];
    assign wdata_7  = wdata_q[7*DW  +: DW];
    assign wdata_8  = wdata_q[8*DW  +: DW];
    assign wdata_9  = wdata_q[9*DW  +: DW];
    assign wdata_10 = wdata_q[10*DW +: DW];
    assign wdata_11 = wdata_q[11*DW +: DW];
    assign wdata_12 = wdata_q[12*DW +: DW];
    assign wdata_13 = wdata_q[13*DW +: DW];
    assign wdata_14 = wdata_q[14*DW +: DW];
    assign wdata_15 = wdata_q[15*DW +: DW];

endmodule
